// File: rtl/ka_operand_split_52bit.sv
// Karatsuba operand splitter: accepts an (A,B) pair and emits the low, middle (lo^hi)
// and high half-operand pairs serially. Optional KA_SPLIT_PERF_CNT_EN adds set_count.
module ka_operand_split_52bit #(
  parameter int N = 52
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N/2-1:0] out_a,
  output logic [N/2-1:0] out_b,
  output logic [1:0]     out_tag,
  output logic           out_last,
`ifdef KA_SPLIT_PERF_CNT_EN
  output logic [15:0]    set_count,
`endif
  output logic           busy
);

  localparam int H = N / 2;

  // Handshake: a beat moves on an edge where valid & ready are both high;
  // valid never drops and data never changes while waiting for ready.

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [H-1:0]   a_mid_q, a_mid_d, a_hi_q, a_hi_d;
  logic [H-1:0]   b_mid_q, b_mid_d, b_hi_q, b_hi_d;
  logic [H-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
  logic [1:0]     out_tag_q, out_tag_d;
  logic           out_last_q, out_last_d;
  logic           out_valid_q, out_valid_d;
  logic           take, last_take, accept;

  always_comb begin
    state_d     = state_q;
    a_mid_d     = a_mid_q;
    a_hi_d      = a_hi_q;
    b_mid_d     = b_mid_q;
    b_hi_d      = b_hi_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_tag_d   = out_tag_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    take      = out_valid_q & out_ready;
    last_take = take & out_last_q;
    in_ready  = (state_q == IDLE) | last_take;
    accept    = in_valid & in_ready;

    if (accept) begin
      // Low beat goes straight to the output register; mid/high wait their turn.
      a_mid_d     = in_a[H-1:0] ^ in_a[N-1:H];
      b_mid_d     = in_b[H-1:0] ^ in_b[N-1:H];
      a_hi_d      = in_a[N-1:H];
      b_hi_d      = in_b[N-1:H];
      out_a_d     = in_a[H-1:0];
      out_b_d     = in_b[H-1:0];
      out_tag_d   = 2'd0;
      out_last_d  = 1'b0;
      out_valid_d = 1'b1;
      state_d     = EMIT;
    end else if (take) begin
      case (out_tag_q)
        2'd0: begin
          out_a_d   = a_mid_q;
          out_b_d   = b_mid_q;
          out_tag_d = 2'd1;
        end
        2'd1: begin
          out_a_d    = a_hi_q;
          out_b_d    = b_hi_q;
          out_tag_d  = 2'd2;
          out_last_d = 1'b1;
        end
        default: begin
          out_a_d     = '0;
          out_b_d     = '0;
          out_tag_d   = 2'd0;
          out_last_d  = 1'b0;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_mid_q     <= '0;
      a_hi_q      <= '0;
      b_mid_q     <= '0;
      b_hi_q      <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_tag_q   <= 2'd0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_mid_q     <= a_mid_d;
      a_hi_q      <= a_hi_d;
      b_mid_q     <= b_mid_d;
      b_hi_q      <= b_hi_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_tag_q   <= out_tag_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_tag   = out_tag_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == EMIT);

`ifdef KA_SPLIT_PERF_CNT_EN
  logic [15:0] set_cnt_q, set_cnt_d;

  always_comb begin
    set_cnt_d = set_cnt_q;
    if (last_take && (set_cnt_q != 16'hFFFF)) set_cnt_d = set_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) set_cnt_q <= 16'd0;
    else        set_cnt_q <= set_cnt_d;
  end

  assign set_count = set_cnt_q;
`endif

endmodule

// File: doc/ka_operand_split_52bit.md
Name: ka_operand_split_52bit

Overview:
- Transmit-side counterpart of the 52-bit overlap/recombine stage in the binary-field (GF(2)) Karatsuba multiplier.
- Accepts one pair of n-bit operands (A, B) over a valid/ready handshake.
- Splits each operand into n/2-bit halves and forms the Karatsuba middle operands (lo XOR hi).
- Emits the three sub-multiply operand pairs serially, one per accepted beat, tagged so the downstream sub-multiplier and overlap stage can route each product.

Parameters:
- n, 52, full operand width; must be even. Half width h = n/2 (26 by default).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept a new operand pair.
- in_a  input  n  operand A (polynomial coefficients, bit 0 = x^0).
- in_b  input  n  operand B.
- out_valid  output  1  sub-operand pair present.
- out_ready  input  1  downstream accepts the pair.
- out_a  output  n/2  sub-operand from A.
- out_b  output  n/2  sub-operand from B.
- out_tag  output  2  0 = low pair, 1 = middle pair, 2 = high pair; 3 is never driven.
- out_last  output  1  high with tag 2.
- busy  output  1  high while an operand set is held (state EMIT).

Behaviour:
- Reset (async assert, sync release): state IDLE; out_valid=0; out_a=0; out_b=0; out_tag=0; out_last=0; busy=0; internal operand registers cleared.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). in_ready is combinational and reads 1 in IDLE, including while rst_n is low.
- Accept = in_valid & in_ready. On accept, register:
  - a_lo = in_a[h-1:0], a_hi = in_a[n-1:h]; b_lo and b_hi likewise.
  - a_mid = a_lo ^ a_hi; b_mid = b_lo ^ b_hi.
  - Pure bitwise XOR; no carries.
- States:
  - IDLE -> EMIT on accept.
  - EMIT -> IDLE when the tag-2 beat is taken and no new accept occurs in the same cycle.
  - EMIT -> EMIT (restart at tag 0) when the tag-2 beat is taken together with a new accept.
- Latency: an operand set accepted at edge k gives out_valid=1 with tag 0 from edge k onward (registered outputs).
- Beat order is fixed: tag 0 (a_lo, b_lo), then tag 1 (a_mid, b_mid), then tag 2 (a_hi, b_hi, out_last=1).
- Tag counter advances only on out_valid & out_ready. It wraps 2 -> 0 only on a same-cycle new accept; otherwise out_valid drops.
- Backpressure: while out_valid & !out_ready, out_a, out_b, out_tag and out_last hold stable.
- Input during EMIT: in_ready=0 except in the final-beat-handshake cycle. The operand registers are never overwritten mid-set.
- Throughput: 3 cycles per set with out_ready held high; no bubble between sets.
- Reset mid-set: the set is discarded, out_valid drops immediately, and no partial set resumes.
- in_valid with in_ready=0: ignored. The source must hold its data (standard valid/ready).

Optional Feature:
- KA_SPLIT_PERF_CNT_EN defined:
  - Adds port set_count output 16: count of completed sets (tag-2 handshakes).
  - Saturates at 16'hFFFF; reset value 0.
  - Increments in the same cycle as the tag-2 handshake.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Basic set: reset, then in_a={26'h3FFFFFF,26'h0000001}, in_b={26'h0000002,26'h0000003}, out_ready=1. Required beats:
  - (a=26'h0000001, b=26'h0000003, tag 0)
  - (a=26'h3FFFFFE, b=26'h0000001, tag 1)
  - (a=26'h3FFFFFF, b=26'h0000002, tag 2, last=1)
  - Then out_valid=0 and in_ready=1.
- Backpressure: same set with out_ready=0 for 4 cycles on tag 1 -> out_a=26'h3FFFFFE and tag=1 held each cycle; in_ready=0 throughout.
- Back-to-back: in_valid held with two sets, out_ready=1 -> 6 consecutive valid beats, tags 0,1,2,0,1,2; in_ready=1 only in IDLE and the two last-beat cycles.
- Reset mid-set: rst_n low after the tag-0 beat -> all outputs 0 at once; after release, a new set starts at tag 0 with the new operands.
- Zero/all-ones: in_a=in_b=52'hFFFFFFFFFFFFF -> middle beat a=b=26'h0; low and high beats a=b=26'h3FFFFFF.
- Counter (macro on): 3 completed sets -> set_count=3. Forcing the count to 16'hFFFF and completing one more set -> remains 16'hFFFF.
